// File: rtl/tug_match_ctrl.sv
// Tug-of-war match sequencer: serves rounds, gates play, scores points, adapts cyber threshold.
// All outputs registered; one-cycle SERVE/POINT states, PAUSE_CYCLES-long inter-round pause.
module tug_match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int CNT_W        = 3,
  parameter int PAUSE_CYCLES = 384,
  parameter int THRESH_STEP  = 32
) (
  input  logic             clkSelect,
  input  logic             reset,
  input  logic             start,
  input  logic             lwin,
  input  logic             rwin,
  input  logic [8:0]       base_thresh,
  output logic             field_reset,
  output logic             play_en,
  output logic [CNT_W-1:0] score_l,
  output logic [CNT_W-1:0] score_r,
  output logic [9:0]       cyber_thresh,
  output logic             match_over,
  output logic [1:0]       winner
);

  localparam int PCNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [PCNT_W-1:0] PAUSE_LAST = PCNT_W'(PAUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WIN        = CNT_W'(WIN_SCORE);
  localparam logic [10:0]       STEP       = 11'(THRESH_STEP);

  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, PAUSE, DONE} state_t;

  state_t            state;
  logic [PCNT_W-1:0] pause_cnt;
  logic              rw_left;
  logic [9:0]        base_q;

  logic [10:0]      up_sum;
  logic [10:0]      dn_limit;
  logic [9:0]       thr_up;
  logic [9:0]       thr_dn;
  logic [CNT_W-1:0] sl_inc;
  logic [CNT_W-1:0] sr_inc;
  logic [CNT_W-1:0] won_score;

  // Floor uses the threshold latched at match start, not the live switches.
  assign up_sum    = {1'b0, cyber_thresh} + STEP;
  assign dn_limit  = {1'b0, base_q} + STEP;
  assign thr_up    = (up_sum > 11'd1023) ? 10'h3FF : up_sum[9:0];
  assign thr_dn    = ({1'b0, cyber_thresh} < dn_limit) ? base_q : cyber_thresh - STEP[9:0];
  assign sl_inc    = (score_l == WIN) ? score_l : score_l + CNT_W'(1);
  assign sr_inc    = (score_r == WIN) ? score_r : score_r + CNT_W'(1);
  assign won_score = rw_left ? sl_inc : sr_inc;

  always_ff @(posedge clkSelect) begin
    if (reset) begin
      state        <= IDLE;
      pause_cnt    <= '0;
      rw_left      <= 1'b0;
      score_l      <= '0;
      score_r      <= '0;
      base_q       <= {1'b0, base_thresh};
      cyber_thresh <= {1'b0, base_thresh};
      field_reset  <= 1'b1;
      play_en      <= 1'b0;
      match_over   <= 1'b0;
      winner       <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SERVE;
            base_q       <= {1'b0, base_thresh};
            cyber_thresh <= {1'b0, base_thresh};
          end
        end
        SERVE: begin
          state       <= PLAY;
          field_reset <= 1'b0;
          play_en     <= 1'b1;
        end
        PLAY: begin
          if (lwin && rwin) begin
            state       <= PAUSE;
            field_reset <= 1'b1;
            play_en     <= 1'b0;
          end else if (lwin || rwin) begin
            state   <= POINT;
            rw_left <= lwin;
            play_en <= 1'b0;
          end
        end
        POINT: begin
          if (rw_left) begin
            score_l      <= sl_inc;
            cyber_thresh <= thr_dn;
          end else begin
            score_r      <= sr_inc;
            cyber_thresh <= thr_up;
          end
          if (won_score == WIN) begin
            state      <= DONE;
            match_over <= 1'b1;
            winner     <= rw_left ? 2'b10 : 2'b01;
          end else begin
            state       <= PAUSE;
            field_reset <= 1'b1;
          end
        end
        PAUSE: begin
          if (pause_cnt == PAUSE_LAST) begin
            pause_cnt <= '0;
            state     <= SERVE;
          end else begin
            pause_cnt <= pause_cnt + PCNT_W'(1);
          end
        end
        DONE: begin
          // Field stays out of reset so the winning edge light remains lit.
          if (start) begin
            state        <= SERVE;
            score_l      <= '0;
            score_r      <= '0;
            base_q       <= {1'b0, base_thresh};
            cyber_thresh <= {1'b0, base_thresh};
            match_over   <= 1'b0;
            winner       <= 2'b00;
            field_reset  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          field_reset <= 1'b1;
          play_en     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tug_match_ctrl.md
Name: tug_match_ctrl

Overview:
- Match sequencer for the tug-of-war game.
- Sits between the conditioned player inputs, the playfield and the score display.
- Holds the playfield in reset between rounds and gates player presses so they only count during live play.
- Tallies round wins to WIN_SCORE, declares the match winner, and adapts the LFSR cyber player's comparator threshold after each point.

Parameters:
WIN_SCORE, 7, round wins needed to take the match (must fit in CNT_W)
CNT_W, 3, score counter width
PAUSE_CYCLES, 384, inter-round pause length in clkSelect cycles (0.5 s at 768 Hz)
THRESH_STEP, 32, cyber threshold adjustment per point

Ports:
clkSelect  in  1  system clock (divided board clock)
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse from a press-conditioned key; begins or restarts a match
lwin  in  1  level; playfield left-edge light on (cyber/left wins round)
rwin  in  1  level; playfield right-edge light on (human/right wins round)
base_thresh  in  9  player-set difficulty (switch bank)
field_reset  out  1  drives the playfield reset (ORed with the global reset outside this block)
play_en  out  1  gates the left/right press pulses into the playfield
score_l  out  CNT_W  left/cyber score
score_r  out  CNT_W  right/human score
cyber_thresh  out  10  threshold to the cyber comparator
match_over  out  1  high while in DONE
winner  out  2  00 none, 10 left, 01 right

Behaviour:
- Interface: reset is synchronous, active-high; clock is clkSelect. Reset overrides all other inputs in any state.
- Reset values:
  - state IDLE; score_l = score_r = 0
  - field_reset = 1, play_en = 0, match_over = 0, winner = 00
  - cyber_thresh = {1'b0, base_thresh}; pause counter = 0
- All outputs are registered or decoded from the registered state only; there is no combinational path from input to output.
- States:
  - IDLE:
    - field_reset = 1, play_en = 0.
    - start -> SERVE; on this transition cyber_thresh loads {0, base_thresh}.
  - SERVE:
    - Lasts exactly 1 cycle; field_reset = 1, play_en = 0.
    - -> PLAY.
  - PLAY:
    - field_reset = 0, play_en = 1.
    - lwin & ~rwin -> POINT, latch rw = L.
    - rwin & ~lwin -> POINT, latch rw = R.
    - lwin & rwin together is a fault/draw: go to PAUSE with no score change.
    - Neither -> stay in PLAY.
  - POINT:
    - Lasts 1 cycle; field_reset = 0, play_en = 0.
    - Increment the latched winner's score. Scores never exceed WIN_SCORE.
    - rw = R: cyber_thresh += THRESH_STEP, saturating at 1023.
    - rw = L: cyber_thresh -= THRESH_STEP, floored at {0, base_thresh}.
    - If the incremented score equals WIN_SCORE -> DONE, else -> PAUSE.
  - PAUSE:
    - field_reset = 1, play_en = 0.
    - Counter runs 0..PAUSE_CYCLES-1, then -> SERVE with the counter cleared.
  - DONE:
    - match_over = 1, winner = rw; field_reset = 0 so the winning edge light stays visible; play_en = 0.
    - start -> clear both scores, reload cyber_thresh from base_thresh, clear winner/match_over, -> SERVE.
- start is ignored in SERVE, PLAY, POINT and PAUSE.
- Changes on base_thresh take effect only at match start.
- Latency:
  - lwin/rwin sampled in cycle n (PLAY): state = POINT in n+1; score and threshold update visible in n+2.
  - PAUSE occupies n+2 .. n+1+PAUSE_CYCLES; SERVE follows; PLAY resumes at n+3+PAUSE_CYCLES.
- start in cycle n (IDLE/DONE): SERVE in n+1, PLAY in n+2.
- Win lights that are still lit on entry to PAUSE are cleared by field_reset. They must not be re-sampled, since only PLAY samples lwin/rwin.

Test Plan:
- Bench uses PAUSE_CYCLES = 4, THRESH_STEP = 32, base_thresh = 100.
- Reset then idle 10 cycles -> field_reset = 1, play_en = 0, scores 0/0, cyber_thresh = 100, winner = 00.
- Start pulse, then rwin high 1 cycle in PLAY -> POINT next cycle; score_r = 1 and cyber_thresh = 132 two cycles after rwin; field_reset high exactly 5 cycles (4 PAUSE + 1 SERVE); play_en returns on the following cycle.
- Seven rwin rounds -> match_over = 1, winner = 01, score_r = 7, cyber_thresh = 324; extra start pulse clears to 0/0, thresh = 100, PLAY two cycles later.
- Seven lwin rounds from base_thresh = 100 -> thresh stays 100 (floor); winner = 10, score_l = 7. With base_thresh = 1000, two rwin points -> thresh saturates at 1023.
- lwin and rwin high in the same PLAY cycle -> no score change, thresh unchanged, PAUSE then SERVE then PLAY.
- Reset asserted mid-PAUSE with score 3/2 -> next cycle IDLE, scores 0/0, counter 0; start pulses during PAUSE/PLAY are ignored.
